// File: rtl/branch_prediction_buffer_if.sv
// Branch prediction buffer ports: DU lookup (port A) and CDB train/lookup (port B).
// The master modport is the requester side (dispatch and CDB logic). The slave
// modport is the buffer.
interface branch_prediction_buffer_if #(
    parameter int DEPTH = 8
);
    localparam int ADDR = $clog2(DEPTH);

    // Port A: dispatch-unit lookup
    logic            du_branch;
    logic [ADDR-1:0] du_bpb_addr;
    logic            bpb_branch_prediction_du;

    // Port B: resolving branch on the CDB (training plus lookup)
    logic            cdb_branch;
    logic            cdb_branch_res;
    logic [ADDR-1:0] cdb_bpb_addr;
    logic            bpb_branch_prediction_cdb;

    modport master (
        output du_branch, du_bpb_addr,
        output cdb_branch, cdb_branch_res, cdb_bpb_addr,
        input  bpb_branch_prediction_du, bpb_branch_prediction_cdb
    );

    modport slave (
        input  du_branch, du_bpb_addr,
        input  cdb_branch, cdb_branch_res, cdb_bpb_addr,
        output bpb_branch_prediction_du, bpb_branch_prediction_cdb
    );
endinterface

// File: rtl/branch_prediction_buffer.sv
// Branch prediction buffer for the Tomasulo core.
// The buffer holds DEPTH saturating counters of WIDTH bits each, indexed by low PC bits.
// A counter predicts taken when its MSB is set.
// Port A gives the dispatch unit a zero-latency prediction.
// Port B trains one counter per cycle from the CDB. It also returns that
// counter's pre-update prediction for mispredict detection.
// Optional macro BPB_FORWARD_EN: a DU lookup that hits the index being trained
// in the same cycle sees the post-update counter.
// reset is asynchronous and active-low. While it is low, every counter is forced
// to weakly taken.
module branch_prediction_buffer #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    branch_prediction_buffer_if.slave     bpb
);

    localparam logic [WIDTH-1:0] WEAK_TAKEN = WIDTH'(1) << (WIDTH - 1);
    localparam logic [WIDTH-1:0] CNT_MAX    = '1;
    localparam logic [WIDTH-1:0] CNT_MIN    = '0;

    logic [WIDTH-1:0] counters [DEPTH];

    logic [WIDTH-1:0] cdb_cur;
    logic [WIDTH-1:0] cdb_next;
    logic [WIDTH-1:0] du_cur;

    // Read the addressed counters and compute the saturated training value for port B.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        cdb_cur  = counters[bpb.cdb_bpb_addr];
        du_cur   = counters[bpb.du_bpb_addr];
        cdb_next = cdb_cur;
        if (bpb.cdb_branch_res) begin
            if (cdb_cur != CNT_MAX) cdb_next = cdb_cur + WIDTH'(1);
        end else begin
            if (cdb_cur != CNT_MIN) cdb_next = cdb_cur - WIDTH'(1);
        end
    end

    // Counter storage: forced to weakly taken while in reset; otherwise one CDB-trained update per cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the counter array is a plain flop array rather than a RAM, so the whole array is reset.
            //       Every entry must start weakly taken.
            for (int i = 0; i < DEPTH; i++) begin
                counters[i] <= WEAK_TAKEN;
            end
        end else if (bpb.cdb_branch) begin
            // NOTE: non-blocking assignment, so readers in the same time step see the pre-edge value.
            counters[bpb.cdb_bpb_addr] <= cdb_next;
        end
    end

    // Port B prediction: pre-update MSB, gated by cdb_branch.
    always_comb begin
        bpb.bpb_branch_prediction_cdb = bpb.cdb_branch & cdb_cur[WIDTH-1];
    end

    // Port A prediction: gated by du_branch, optionally forwarding same-cycle training.
    always_comb begin
        bpb.bpb_branch_prediction_du = 1'b0;
        if (bpb.du_branch) begin
`ifdef BPB_FORWARD_EN
            if (bpb.cdb_branch && (bpb.du_bpb_addr == bpb.cdb_bpb_addr)) begin
                bpb.bpb_branch_prediction_du = cdb_next[WIDTH-1];
            end else begin
                bpb.bpb_branch_prediction_du = du_cur[WIDTH-1];
            end
`else
            bpb.bpb_branch_prediction_du = du_cur[WIDTH-1];
`endif
        end
    end

endmodule

// File: tb/tb_branch_prediction_buffer.sv
// Self-checking bench for branch_prediction_buffer (DEPTH=8, WIDTH=2).
// Each step pushes its expected predictions to a scoreboard queue when the
// stimulus is driven. The matching entry is popped and compared mid-cycle.
// Expectations for same-index DU reads follow BPB_FORWARD_EN.
module tb_branch_prediction_buffer;

    logic clk = 1'b0;
    logic reset;

    branch_prediction_buffer_if #(.DEPTH(8)) bpb_if ();

    branch_prediction_buffer #(.DEPTH(8), .WIDTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bpb   (bpb_if.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        logic  du;
        logic  cdb;
    } exp_t;

    exp_t sb[$];
    int   n_compared   = 0;
    int   n_mismatched = 0;

    // Drive one set of port inputs and queue the expected outputs.
    task automatic drive(input logic du_b, input logic [2:0] du_a,
                         input logic cdb_b, input logic cdb_r, input logic [2:0] cdb_a,
                         input logic exp_du, input logic exp_cdb, input string tag);
        bpb_if.du_branch      = du_b;
        bpb_if.du_bpb_addr    = du_a;
        bpb_if.cdb_branch     = cdb_b;
        bpb_if.cdb_branch_res = cdb_r;
        bpb_if.cdb_bpb_addr   = cdb_a;
        sb.push_back('{tag: tag, du: exp_du, cdb: exp_cdb});
    endtask

    // Pop the oldest expectation and compare both predictions.
    task automatic compare();
        exp_t e;
        if (sb.size() == 0) begin
            n_compared++;
            n_mismatched++;
            $error("FAIL scoreboard_empty: observed 0 entries, expected at least 1");
        end else begin
            e = sb.pop_front();
            n_compared++;
            assert (bpb_if.bpb_branch_prediction_du === e.du) else begin
                n_mismatched++;
                $error("FAIL %s du: observed %b expected %b", e.tag, bpb_if.bpb_branch_prediction_du, e.du);
            end
            n_compared++;
            assert (bpb_if.bpb_branch_prediction_cdb === e.cdb) else begin
                n_mismatched++;
                $error("FAIL %s cdb: observed %b expected %b", e.tag, bpb_if.bpb_branch_prediction_cdb, e.cdb);
            end
        end
    endtask

    // One clocked step: drive after a rising edge, check at the falling edge, and let the next rising edge commit.
    task automatic step(input logic du_b, input logic [2:0] du_a,
                        input logic cdb_b, input logic cdb_r, input logic [2:0] cdb_a,
                        input logic exp_du, input logic exp_cdb, input string tag);
        drive(du_b, du_a, cdb_b, cdb_r, cdb_a, exp_du, exp_cdb, tag);
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic up_cdb   [4];
        logic up_fwd   [4];
        logic dn_cdb   [6];
        logic dn_fwd   [6];
        logic up_du_exp;
        logic dn_du_exp;

        up_cdb = '{1'b1, 1'b1, 1'b1, 1'b1};   // pre-update counters 10,11,11,11
        up_fwd = '{1'b1, 1'b1, 1'b1, 1'b1};   // post-update counters 11,11,11,11
        dn_cdb = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // pre-update 11,10,01,00,00,00
        dn_fwd = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // post-update 10,01,00,00,00,00

        reset = 1'b0;
        drive(1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, "in_reset");
        repeat (3) @(posedge clk);
        #1;
        compare();
        reset = 1'b1;

        // 1. Reset state: every index weakly taken, with no training.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 3'(i), 1'b0, 1'b0, 3'(i), 1'b1, 1'b0, $sformatf("reset_idx%0d", i));
        end

        // 2-4. Saturate up then down on each index, with the DU reading the same index.
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 4; k++) begin
`ifdef BPB_FORWARD_EN
                up_du_exp = up_fwd[k];
`else
                up_du_exp = up_cdb[k];
`endif
                step(1'b1, 3'(i), 1'b1, 1'b1, 3'(i), up_du_exp, up_cdb[k],
                     $sformatf("sat_up_idx%0d_c%0d", i, k));
            end
            for (int k = 0; k < 6; k++) begin
`ifdef BPB_FORWARD_EN
                dn_du_exp = dn_fwd[k];
`else
                dn_du_exp = dn_cdb[k];
`endif
                step(1'b1, 3'(i), 1'b1, 1'b0, 3'(i), dn_du_exp, dn_cdb[k],
                     $sformatf("sat_dn_idx%0d_c%0d", i, k));
            end
        end

        // Every counter is now 00: the DU reads not-taken everywhere.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 3'(i), 1'b0, 1'b0, 3'(i), 1'b0, 1'b0, $sformatf("all_zero_idx%0d", i));
        end

        // 6. Async reset between clock edges: all entries read weakly taken at once.
        @(negedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'(i), 1'b1, 1'b1, 3'(i), 1'b1, 1'b1, $sformatf("async_rst_idx%0d", i));
            #1;
            compare();
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // 5. Isolation: train index 3 down to 00 while the DU reads index 4.
        step(1'b1, 3'd4, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, "iso_dec1");
        step(1'b1, 3'd4, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, "iso_dec2");
        step(1'b1, 3'd4, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, "iso_dec3");
        step(1'b1, 3'd3, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, "iso_idx3_zero");

        // Gating: with cdb_branch=0, the CDB output is 0 and no training takes place.
        step(1'b1, 3'd3, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, "gate_cdb_off1");
        step(1'b1, 3'd3, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, "gate_cdb_off2");
        step(1'b1, 3'd3, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, "gate_idx3_held");
        // With du_branch=0, the DU output is 0 even for a taken entry.
        step(1'b0, 3'd4, 1'b1, 1'b1, 3'd4, 1'b0, 1'b1, "gate_du_off");
        step(1'b1, 3'd4, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, "gate_idx4_after");
        // A DU read and a CDB write to different indices are independent.
        step(1'b1, 3'd3, 1'b1, 1'b1, 3'd5, 1'b0, 1'b1, "indep_du3_cdb5");
        step(1'b1, 3'd5, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, "indep_du5_cdb3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/branch_prediction_buffer.md
Name: branch_prediction_buffer

Overview:
Branch prediction buffer for the Tomasulo core: DEPTH entries, each a WIDTH-bit saturating counter, indexed by low PC bits.
- Dispatch unit (DU) gets a combinational taken/not-taken prediction for a branch being dispatched.
- The CDB side trains the addressed counter when a branch resolves, and also reads that entry's prediction for the resolving branch.
- Read port A belongs to the DU; read/write port B belongs to the CDB.

Parameters:
DEPTH, 8, number of counter entries (power of two).
WIDTH, 2, counter width in bits.
ADDR, $clog2(DEPTH), index width (derived; not overridden).

Ports:
clk  input  1  clock, rising-edge.
reset  input  1  asynchronous, active-low reset.
du_branch  input  1  DU lookup valid.
du_bpb_addr  input  ADDR  DU lookup index.
bpb_branch_prediction_du  output  1  prediction for the DU lookup (1 = taken).
cdb_branch  input  1  CDB resolved-branch valid; enables update.
cdb_branch_res  input  1  actual outcome (1 = taken).
cdb_bpb_addr  input  ADDR  index of the resolving branch.
bpb_branch_prediction_cdb  output  1  stored prediction for cdb_bpb_addr (pre-update).

Behaviour:
- Storage: DEPTH × WIDTH-bit unsigned counters. Prediction = counter MSB (taken when counter ≥ 2^(WIDTH-1)).
- Reset (reset=0, async): all counters = 2^(WIDTH-1), i.e. weakly taken (2'b10). Outputs then read 1 if their valid is high.
- Update: on rising clk with reset=1 and cdb_branch=1, counter[cdb_bpb_addr] changes as follows:
  - cdb_branch_res=1: +1, saturating at 2^WIDTH-1 (11 stays 11).
  - cdb_branch_res=0: -1, saturating at 0 (00 stays 00).
  - cdb_branch=0: no state change.
- bpb_branch_prediction_cdb:
  - Combinational MSB of the current (pre-update) counter[cdb_bpb_addr] when cdb_branch=1.
  - 0 when cdb_branch=0.
  - The ROB/branch logic compares it with cdb_branch_res to detect mispredicts.
- bpb_branch_prediction_du:
  - Combinational, zero latency.
  - 0 when du_branch=0.
  - Otherwise MSB of counter[du_bpb_addr], subject to forwarding (see Optional Feature).
- Both addresses are always in range (DEPTH power of two); no wrap handling needed.
- Simultaneous DU read and CDB write to different indices are independent.
- Reset asserted mid-operation overrides any pending update in that cycle.
- Only one update per cycle; no other write source.

Optional Feature:
Macro BPB_FORWARD_EN (defined in default core build).
- Defined: when du_branch=1, cdb_branch=1 and du_bpb_addr==cdb_bpb_addr, bpb_branch_prediction_du = MSB of the post-update (saturated next-state) counter. The DU thereby sees the training from the same cycle.
- Undefined: DU always reads the stored (pre-update) counter. The same-cycle update becomes visible on the following cycle.

Test Plan:
1. Reset check:
   - Stimulus: hold reset=0 for 3 cycles, release, du_branch=1, sweep du_bpb_addr 0..7 one per cycle, cdb_branch=0.
   - Required: bpb_branch_prediction_du=1 for every index; no state change.
2. Saturate up, per index i:
   - Stimulus: cdb_branch=1, cdb_bpb_addr=i, cdb_branch_res=1 for 4 cycles.
   - Required: counter goes 10→11→11→11.
   - Required: cdb prediction =1 in every one of those cycles.
3. Saturate down (follows scenario 2):
   - Stimulus: cdb_branch_res=0 for 6 cycles.
   - Required: counter goes 11→10→01→00→00→00.
   - Required: cdb prediction reads 1,1,0,0,0,0.
4. Forwarding, with du_bpb_addr=cdb_bpb_addr during scenarios 2–3:
   - With BPB_FORWARD_EN: DU prediction equals the next-state MSB, so it reads 0 already in the cycle where 10→01.
   - Without the macro: DU prediction equals the cdb prediction.
5. Isolation and gating:
   - Stimulus: update index 3 to 00; read index 4.
   - Required: index 4 still predicts 1.
   - Required: du_branch=0 or cdb_branch=0 forces the corresponding output to 0 and blocks updates.
6. Async reset mid-run:
   - Stimulus: drive several counters to 00, pulse reset low between clock edges.
   - Required: all entries immediately read 1 (10).
